fp_norm_round_pipe: RTL and testbench

Parametrised two-stage pipelined normalise-and-round unit for the floating-point adder datapath. It takes the raw post-add significand with its carry, guard, round and sticky bits, biased exponent and sign. It produces an IEEE-754-style normalised, rounded result with status flags. It adds four rounding modes, subnormal handling, overflow saturation and a valid/ready handshake, replacing the single-cycle combinational normaliser.

---
 rtl/fp_norm_round_pipe.sv | 181 ++++++++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise-and-round unit for the FP adder: stage 1 normalises the raw
// sum (carry shift, leading-zero shift, subnormal clamp), stage 2 rounds and packs.
module fp_norm_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [MAN_W+1:0] in_sum,
   input  logic [2:0]       in_ext,
   input  logic [1:0]       in_rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic [3:0]       out_flags
);

   localparam int WW  = MAN_W + 5;
   localparam int NW  = MAN_W + 4;
   localparam int XW  = EXP_W + 2;
   localparam int LZW = $clog2(WW);
   localparam logic signed [XW-1:0] MAX_EXP = XW'((1 << EXP_W) - 1);

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   logic s1Valid, s1Sign, s1Zero;
   logic [1:0] s1Rm;
   logic [NW-1:0] s1W;
   logic signed [XW-1:0] s1Exp;

   logic s1Adv, s2Adv;
   assign s2Adv    = !out_valid || out_ready;
   assign s1Adv    = !s1Valid || s2Adv;
   assign in_ready = s1Adv;

   logic [WW-1:0] wIn;
   assign wIn = {in_sum, in_ext};

   // Lowest-index hit is overwritten by higher ones, leaving the leading one.
   logic [LZW-1:0] lzc;
   always_comb begin
      lzc = '0;
      for (int i = 0; i <= MAN_W + 3; i++) begin
         if (wIn[i]) lzc = LZW'(MAN_W + 3 - i);
      end
   end

   logic [XW-1:0] expExt, lzcExt;
   logic [LZW-1:0] subShift;
   logic [NW-1:0] normW;
   logic signed [XW-1:0] normExp;
   logic normZero;

   assign expExt = {2'b00, in_exp};
   assign lzcExt = {{(XW-LZW){1'b0}}, lzc};

   always_comb begin
      normW    = '0;
      normExp  = '0;
      normZero = 1'b0;
      subShift = '0;
      if (wIn == '0) begin
         normZero = 1'b1;
      end else if (wIn[WW-1]) begin
         normW   = {wIn[WW-1:2], wIn[1] | wIn[0]};
         normExp = $signed(expExt + XW'(1));
      end else if (expExt > lzcExt) begin
         normW   = wIn[NW-1:0] << lzc;
         normExp = $signed(expExt - lzcExt);
      end else begin
         // in_exp <= lzc here, so in_exp-1 always fits the shifter width
         subShift = (in_exp == '0) ? '0 : LZW'(in_exp - EXP_W'(1));
         normW    = wIn[NW-1:0] << subShift;
         normExp  = XW'(1);
      end
   end

   logic hid, gBit, rBit, sBit, lsb, inexactBits, inc;
   logic [MAN_W-1:0] frac;
   logic [MAN_W+1:0] rounded;
   logic carry, newHid, ovf, toInf;
   logic signed [XW-1:0] finExp;
   logic [EXP_W-1:0] resExp;
   logic [MAN_W-1:0] resMan;
   logic [3:0] resFlags;
   logic inexact, underflow;

   assign hid  = s1W[NW-1];
   assign frac = s1W[NW-2:3];
   assign gBit = s1W[2];
   assign rBit = s1W[1];
   assign sBit = s1W[0];
   assign lsb  = s1W[3];
   assign inexactBits = gBit | rBit | sBit;

   always_comb begin
      inc = 1'b0;
      case (s1Rm)
         RM_RNE:  inc = gBit & (rBit | sBit | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = !s1Sign & inexactBits;
         RM_RDN:  inc = s1Sign & inexactBits;
         default: inc = 1'b0;
      endcase
   end

   // A carry out leaves the fraction at zero; a subnormal rounding into the
   // hidden bit keeps exponent 1, which is already its encoding.
   assign rounded = {1'b0, hid, frac} + (MAN_W+2)'(inc);
   assign carry   = rounded[MAN_W+1];
   assign newHid  = rounded[MAN_W] | carry;
   assign finExp  = s1Exp + $signed({{(XW-1){1'b0}}, carry});
   assign ovf     = !s1Zero && (finExp >= MAX_EXP);
   assign toInf   = (s1Rm == RM_RNE) || (s1Rm == RM_RUP && !s1Sign) ||
                    (s1Rm == RM_RDN && s1Sign);

   always_comb begin
      resExp = '0;
      resMan = '0;
      if (s1Zero) begin
         resExp = '0;
         resMan = '0;
      end else if (ovf) begin
         resExp = toInf ? '1 : {{(EXP_W-1){1'b1}}, 1'b0};
         resMan = toInf ? '0 : '1;
      end else begin
         resExp = newHid ? finExp[EXP_W-1:0] : '0;
         resMan = rounded[MAN_W-1:0];
      end
   end

   assign inexact   = !s1Zero && (inexactBits || ovf);
   assign underflow = inexact && !ovf && !newHid;
   assign resFlags  = {ovf, underflow, inexact, (resExp == '0) && (resMan == '0)};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1Valid   <= 1'b0;
         s1Sign    <= 1'b0;
         s1Zero    <= 1'b0;
         s1Rm      <= '0;
         s1W       <= '0;
         s1Exp     <= '0;
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_exp   <= '0;
         out_man   <= '0;
         out_flags <= '0;
      end else begin
         if (s1Adv) begin
            s1Valid <= in_valid;
            if (in_valid) begin
               s1Sign <= in_sign;
               s1Zero <= normZero;
               s1Rm   <= in_rm;
               s1W    <= normW;
               s1Exp  <= normExp;
            end
         end
         if (s2Adv) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
               out_sign  <= s1Sign;
               out_exp   <= resExp;
               out_man   <= resMan;
               out_flags <= resFlags;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Bench for fp_norm_round_pipe: vector table through a scoreboard, plus
// backpressure and reset corner sequences.
module tb_fp_norm_round_pipe;

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, in_sign, out_valid, out_ready, out_sign;
   logic [7:0] in_exp, out_exp;
   logic [24:0] in_sum;
   logic [2:0] in_ext;
   logic [1:0] in_rm;
   logic [22:0] out_man;
   logic [3:0] out_flags;

   int compared = 0;
   int mismatched = 0;
   int cycle = 0;
   int beatsSeen = 0;
   bit latCheck = 1'b0;
   bit randStall = 1'b0;

   typedef struct {
      logic sign; logic [7:0] e; logic [24:0] sum; logic [2:0] ext; logic [1:0] rm;
      logic [7:0] xExp; logic [22:0] xMan; logic [3:0] xFlags;
   } vec_t;

   typedef struct {
      logic sign; logic [7:0] xExp; logic [22:0] xMan; logic [3:0] xFlags;
      int cyc; bit lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum), .in_ext(in_ext), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man), .out_flags(out_flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   always @(posedge clk) begin
      if (randStall) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         compared++;
         beatsSeen++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_beat: got s=%0b e=%h m=%h f=%b, required no output",
                     out_sign, out_exp, out_man, out_flags);
         end else begin
            e = sb.pop_front();
            if (out_sign !== e.sign || out_exp !== e.xExp || out_man !== e.xMan ||
                out_flags !== e.xFlags || (e.lat && (cycle - e.cyc) != 2)) begin
               mismatched++;
               $display("FAIL beat: got s=%0b e=%h m=%h f=%b lat=%0d, required s=%0b e=%h m=%h f=%b lat=2",
                        out_sign, out_exp, out_man, out_flags, cycle - e.cyc,
                        e.sign, e.xExp, e.xMan, e.xFlags);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic addVec(input logic s, input logic [7:0] e, input logic [24:0] sum,
                         input logic [2:0] ext, input logic [1:0] rm, input logic [7:0] xe,
                         input logic [22:0] xm, input logic [3:0] xf);
      vec_t v;
      v = '{s, e, sum, ext, rm, xe, xm, xf};
      vecs.push_back(v);
   endtask

   task automatic applyInputs(input vec_t v);
      in_sign = v.sign; in_exp = v.e; in_sum = v.sum; in_ext = v.ext; in_rm = v.rm;
   endtask

   task automatic pushExp(input vec_t v);
      exp_t x;
      x = '{v.sign, v.xExp, v.xMan, v.xFlags, cycle, latCheck};
      sb.push_back(x);
   endtask

   // Entered and left at posedge+1.
   task automatic sendBeat(input vec_t v);
      int n = 0;
      in_valid = 1'b1;
      applyInputs(v);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: got in_ready=0, required 1");
      end else begin
         pushExp(v);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int seen0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_sign = 1'b0; in_exp = '0; in_sum = '0; in_ext = '0; in_rm = '0;

      addVec(0, 127, 25'h1800000, 3'b000, 2'd0, 8'h80, 23'h400000, 4'b0000); // carry
      addVec(0, 127, 25'h0000100, 3'b000, 2'd0, 8'h70, 23'h000000, 4'b0000); // cancel
      addVec(0,   3, 25'h0000100, 3'b000, 2'd0, 8'h00, 23'h000400, 4'b0000);
      addVec(0, 127, 25'h0800001, 3'b100, 2'd0, 8'h7F, 23'h000002, 4'b0010); // RNE tie odd
      addVec(0, 127, 25'h0800000, 3'b100, 2'd0, 8'h7F, 23'h000000, 4'b0010); // RNE tie even
      addVec(1, 127, 25'h0800000, 3'b100, 2'd2, 8'h7F, 23'h000000, 4'b0010);
      addVec(0, 127, 25'h0FFFFFF, 3'b110, 2'd0, 8'h80, 23'h000000, 4'b0010); // round carry
      addVec(0, 254, 25'h1000000, 3'b000, 2'd0, 8'hFF, 23'h000000, 4'b1010); // overflow
      addVec(0, 254, 25'h1000000, 3'b000, 2'd1, 8'hFE, 23'h7FFFFF, 4'b1010);
      addVec(1, 254, 25'h1000000, 3'b000, 2'd2, 8'hFE, 23'h7FFFFF, 4'b1010);
      addVec(1, 254, 25'h1000000, 3'b000, 2'd3, 8'hFF, 23'h000000, 4'b1010);
      addVec(0, 254, 25'h1000000, 3'b000, 2'd3, 8'hFE, 23'h7FFFFF, 4'b1010);
      addVec(1, 100, 25'h0000000, 3'b000, 2'd0, 8'h00, 23'h000000, 4'b0001); // zero
      addVec(0, 127, 25'h0800000, 3'b001, 2'd2, 8'h7F, 23'h000001, 4'b0010);
      addVec(1, 127, 25'h0800000, 3'b001, 2'd3, 8'h7F, 23'h000001, 4'b0010);
      addVec(0, 127, 25'h0800000, 3'b001, 2'd3, 8'h7F, 23'h000000, 4'b0010);
      addVec(0,   1, 25'h07FFFFF, 3'b100, 2'd0, 8'h01, 23'h000000, 4'b0010); // sub -> normal
      addVec(0,   1, 25'h0000003, 3'b010, 2'd0, 8'h00, 23'h000003, 4'b0110); // underflow
      addVec(0,   1, 25'h0000000, 3'b100, 2'd1, 8'h00, 23'h000000, 4'b0111);
      addVec(0, 127, 25'h1000001, 3'b000, 2'd2, 8'h80, 23'h000001, 4'b0010); // carry sticky
      addVec(0,   0, 25'h0000010, 3'b000, 2'd0, 8'h00, 23'h000010, 4'b0000);
      addVec(0,  16, 25'h0000100, 3'b000, 2'd0, 8'h01, 23'h000000, 4'b0000); // exp = lzc+1
      addVec(0,  15, 25'h0000100, 3'b000, 2'd0, 8'h00, 23'h400000, 4'b0000); // exp = lzc

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", {out_valid, out_sign, out_exp, out_man, out_flags, in_ready},
            {1'b0, 1'b0, 8'h00, 23'h0, 4'h0, 1'b1});
      @(posedge clk); #1;

      // Back-to-back, no stalls: latency is checked per beat.
      latCheck = 1'b1;
      foreach (vecs[i]) sendBeat(vecs[i]);
      drain();
      latCheck = 1'b0;

      // Same table under random consumer stalls.
      randStall = 1'b1;
      foreach (vecs[i]) sendBeat(vecs[i]);
      randStall = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      // Backpressure: two beats fill the pipe, the third waits.
      out_ready = 1'b0;
      sendBeat(vecs[0]);
      sendBeat(vecs[7]);
      in_valid = 1'b1;
      applyInputs(vecs[3]);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_hold", {out_valid, out_exp, out_man, out_flags},
               {1'b1, 8'h80, 23'h400000, 4'b0000});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("resume_in_ready", 64'(in_ready), 64'd1);
      pushExp(vecs[3]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Reset with two beats in flight.
      out_ready = 1'b0;
      sendBeat(vecs[1]);
      sendBeat(vecs[2]);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      check("post_reset", {out_valid, out_sign, out_exp, out_man, out_flags, in_ready},
            {1'b0, 1'b0, 8'h00, 23'h0, 4'h0, 1'b1});
      seen0 = beatsSeen;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("no_stale_beat", 64'(beatsSeen), 64'(seen0));
      @(posedge clk); #1;

      // A beat offered during reset is not accepted.
      seen0 = beatsSeen;
      reset = 1'b1;
      in_valid = 1'b1;
      applyInputs(vecs[0]);
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_drops_beat", {64'(beatsSeen)}, {64'(seen0)});
      check("reset_drops_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;

      sendBeat(vecs[4]);
      sendBeat(vecs[17]);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
